// File: rtl/riscv_instr_decoder_if.sv
// Shared RV32I decode encodings, plus the bundle that links fetch to the
// main decoder and carries every datapath control the decoder produces.
package riscv_decoder_pkg;
  localparam int ALU_OP_WIDTH = 5;

  localparam logic [1:0] OP_A_RS1     = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;

  localparam logic [2:0] OP_B_RS2   = 3'd0;
  localparam logic [2:0] OP_B_IMM_I = 3'd1;
  localparam logic [2:0] OP_B_IMM_U = 3'd2;
  localparam logic [2:0] OP_B_IMM_S = 3'd3;
  localparam logic [2:0] OP_B_INCR  = 3'd4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'b00000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'b01000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'b00100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'b00110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'b00111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'b01101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'b00101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'b00001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 5'b11100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 5'b11110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES  = 5'b11101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 5'b11111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 5'b11000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 5'b11001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 5'b00010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'b00011;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  localparam logic WB_EX_RESULT = 1'b0;
  localparam logic WB_LSU_DATA  = 1'b1;

  localparam logic [4:0] LOAD_OPCODE     = 5'b00000;
  localparam logic [4:0] MISC_MEM_OPCODE = 5'b00011;
  localparam logic [4:0] OP_IMM_OPCODE   = 5'b00100;
  localparam logic [4:0] AUIPC_OPCODE    = 5'b00101;
  localparam logic [4:0] STORE_OPCODE    = 5'b01000;
  localparam logic [4:0] OP_OPCODE       = 5'b01100;
  localparam logic [4:0] LUI_OPCODE      = 5'b01101;
  localparam logic [4:0] BRANCH_OPCODE   = 5'b11000;
  localparam logic [4:0] JALR_OPCODE     = 5'b11001;
  localparam logic [4:0] JAL_OPCODE      = 5'b11011;
  localparam logic [4:0] SYSTEM_OPCODE   = 5'b11100;
endpackage

interface riscv_instr_decoder_if;
  import riscv_decoder_pkg::*;
  logic [31:0]             fetched_instr_i;
  logic [1:0]              ex_op_a_sel_o;
  logic [2:0]              ex_op_b_sel_o;
  logic [ALU_OP_WIDTH-1:0] alu_op_o;
  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [2:0]              mem_size_o;
  logic                    gpr_we_a_o;
  logic                    wb_src_sel_o;
  logic                    illegal_instr_o;
  logic                    branch_o;
  logic                    jal_o;
  logic                    jalr_o;

  modport master (
    output fetched_instr_i,
    input  ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o, mem_req_o, mem_we_o, mem_size_o,
           gpr_we_a_o, wb_src_sel_o, illegal_instr_o, branch_o, jal_o, jalr_o
  );
  modport slave (
    input  fetched_instr_i,
    output ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o, mem_req_o, mem_we_o, mem_size_o,
           gpr_we_a_o, wb_src_sel_o, illegal_instr_o, branch_o, jal_o, jalr_o
  );
endinterface

// File: rtl/riscv_instr_decoder.sv
// RV32I main decoder: purely combinational map from an instruction word to
// datapath controls; illegal words fall back to the default control set.
module riscv_instr_decoder
  import riscv_decoder_pkg::*;
(
  input logic                  clk_i,
  input logic                  arstn_i,
  riscv_instr_decoder_if.slave bus
);
  logic [31:0]             instr;
  logic [4:0]              opcode;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic [1:0]              opA;
  logic [2:0]              opB;
  logic [ALU_OP_WIDTH-1:0] aluOp;
  logic                    memReq, memWe, gprWe, wbSel, illegal, branch, jal, jalr;
  logic [2:0]              memSize;
  logic                    unusedBits;

  assign instr  = bus.fetched_instr_i;
  assign opcode = instr[6:2];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Clock/reset and register/immediate fields are not part of decode.
  assign unusedBits = ^{clk_i, arstn_i, instr[24:15], instr[11:7]};

  // Shared OP / OP_IMM mapping; alt selects SUB / SRA.
  function automatic logic [ALU_OP_WIDTH-1:0] arithOp(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    arithOp = alt ? ALU_SUB : ALU_ADD;
      3'd1:    arithOp = ALU_SLL;
      3'd2:    arithOp = ALU_SLTS;
      3'd3:    arithOp = ALU_SLTU;
      3'd4:    arithOp = ALU_XOR;
      3'd5:    arithOp = alt ? ALU_SRA : ALU_SRL;
      3'd6:    arithOp = ALU_OR;
      default: arithOp = ALU_AND;
    endcase
  endfunction

  always_comb begin
    opA = OP_A_RS1; opB = OP_B_IMM_I; aluOp = ALU_ADD; memSize = LDST_W;
    wbSel = WB_EX_RESULT; memReq = 1'b0; memWe = 1'b0; gprWe = 1'b0;
    branch = 1'b0; jal = 1'b0; jalr = 1'b0; illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode)
        LOAD_OPCODE: begin
          memReq = 1'b1; gprWe = 1'b1; wbSel = WB_LSU_DATA; memSize = funct3;
          illegal = !(funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        end
        MISC_MEM_OPCODE, SYSTEM_OPCODE: ;
        OP_IMM_OPCODE: begin
          gprWe = 1'b1;
          aluOp = arithOp(funct3, funct3 == 3'd5 && funct7 == 7'h20);
          illegal = (funct3 == 3'd1 && funct7 != 7'h00) ||
                    (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20);
        end
        AUIPC_OPCODE: begin
          opA = OP_A_CURR_PC; opB = OP_B_IMM_U; gprWe = 1'b1;
        end
        STORE_OPCODE: begin
          opB = OP_B_IMM_S; memReq = 1'b1; memWe = 1'b1; memSize = funct3;
          illegal = funct3 > 3'd2;
        end
        OP_OPCODE: begin
          opB = OP_B_RS2; gprWe = 1'b1;
          aluOp = arithOp(funct3, funct7 == 7'h20);
          illegal = !(funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
        end
        LUI_OPCODE: begin
          opA = OP_A_ZERO; opB = OP_B_IMM_U; gprWe = 1'b1;
        end
        BRANCH_OPCODE: begin
          opB = OP_B_RS2; branch = 1'b1;
          case (funct3)
            3'd0:    aluOp = ALU_EQ;
            3'd1:    aluOp = ALU_NE;
            3'd4:    aluOp = ALU_LTS;
            3'd5:    aluOp = ALU_GES;
            3'd6:    aluOp = ALU_LTU;
            3'd7:    aluOp = ALU_GEU;
            default: illegal = 1'b1;
          endcase
        end
        JALR_OPCODE: begin
          opA = OP_A_CURR_PC; opB = OP_B_INCR; gprWe = 1'b1; jalr = 1'b1;
        end
        JAL_OPCODE: begin
          opA = OP_A_CURR_PC; opB = OP_B_INCR; gprWe = 1'b1; jal = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
    // Illegal words collapse to the default set so every output stays legal.
    if (illegal) begin
      opA = OP_A_RS1; opB = OP_B_IMM_I; aluOp = ALU_ADD; memSize = LDST_W;
      wbSel = WB_EX_RESULT; memReq = 1'b0; memWe = 1'b0; gprWe = 1'b0;
      branch = 1'b0; jal = 1'b0; jalr = 1'b0;
    end
  end

  assign bus.ex_op_a_sel_o   = opA;
  assign bus.ex_op_b_sel_o   = opB;
  assign bus.alu_op_o        = aluOp;
  assign bus.mem_req_o       = memReq;
  assign bus.mem_we_o        = memWe;
  assign bus.mem_size_o      = memSize;
  assign bus.gpr_we_a_o      = gprWe;
  assign bus.wb_src_sel_o    = wbSel;
  assign bus.illegal_instr_o = illegal;
  assign bus.branch_o        = branch;
  assign bus.jal_o           = jal;
  assign bus.jalr_o          = jalr;
endmodule

// File: tb/tb_riscv_instr_decoder.sv
// Bench for the RV32I main decoder: directed words plus randomized words
// compared field-by-field against a table-driven reference model.
module tb_riscv_instr_decoder;
  import riscv_decoder_pkg::*;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  int   passCnt = 0;
  int   totalCnt = 0;
  int   failCnt = 0;

  always #5 clk = ~clk;

  riscv_instr_decoder_if ifc();
  riscv_instr_decoder dut (.clk_i(clk), .arstn_i(arstn), .bus(ifc));

  typedef struct packed {
    logic [1:0] a; logic [2:0] b; logic [4:0] alu; logic req; logic we;
    logic [2:0] size; logic gpr; logic wb; logic ill; logic br; logic jal; logic jalr;
  } ctlT;

  // Reference tables indexed by funct3.
  logic [4:0] regAlu [8] = '{ALU_ADD, ALU_SLL, ALU_SLTS, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  logic [4:0] brAlu  [8] = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD, ALU_LTS, ALU_GES, ALU_LTU, ALU_GEU};
  logic [7:0] loadOk  = 8'b0011_0111;
  logic [7:0] storeOk = 8'b0000_0111;
  logic [7:0] brOk    = 8'b1111_0011;

  function automatic ctlT model(input logic [31:0] w);
    ctlT dflt, e;
    logic [4:0] op; logic [2:0] f3; logic [6:0] f7; bit legal;
    dflt = '{a: OP_A_RS1, b: OP_B_IMM_I, alu: ALU_ADD, req: 0, we: 0, size: LDST_W,
             gpr: 0, wb: WB_EX_RESULT, ill: 0, br: 0, jal: 0, jalr: 0};
    e = dflt; op = w[6:2]; f3 = w[14:12]; f7 = w[31:25]; legal = 0;
    if (w[1:0] == 2'b11) begin
      if (op == LOAD_OPCODE && loadOk[f3]) begin
        legal = 1; e.req = 1; e.gpr = 1; e.wb = WB_LSU_DATA; e.size = f3;
      end
      if (op == MISC_MEM_OPCODE || op == SYSTEM_OPCODE) legal = 1;
      if (op == OP_IMM_OPCODE) begin
        legal = !(f3 == 1 || f3 == 5) || f7 == 7'h00 || (f3 == 5 && f7 == 7'h20);
        e.gpr = 1; e.alu = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : regAlu[f3];
      end
      if (op == AUIPC_OPCODE) begin legal = 1; e.a = OP_A_CURR_PC; e.b = OP_B_IMM_U; e.gpr = 1; end
      if (op == LUI_OPCODE)   begin legal = 1; e.a = OP_A_ZERO;    e.b = OP_B_IMM_U; e.gpr = 1; end
      if (op == STORE_OPCODE && storeOk[f3]) begin
        legal = 1; e.b = OP_B_IMM_S; e.req = 1; e.we = 1; e.size = f3;
      end
      if (op == OP_OPCODE) begin
        e.b = OP_B_RS2; e.gpr = 1;
        if (f7 == 7'h00) begin legal = 1; e.alu = regAlu[f3]; end
        if (f7 == 7'h20 && f3 == 0) begin legal = 1; e.alu = ALU_SUB; end
        if (f7 == 7'h20 && f3 == 5) begin legal = 1; e.alu = ALU_SRA; end
      end
      if (op == BRANCH_OPCODE && brOk[f3]) begin
        legal = 1; e.b = OP_B_RS2; e.br = 1; e.alu = brAlu[f3];
      end
      if (op == JALR_OPCODE) begin legal = 1; e.a = OP_A_CURR_PC; e.b = OP_B_INCR; e.gpr = 1; e.jalr = 1; end
      if (op == JAL_OPCODE)  begin legal = 1; e.a = OP_A_CURR_PC; e.b = OP_B_INCR; e.gpr = 1; e.jal = 1; end
    end
    if (!legal) begin e = dflt; e.ill = 1; end
    return e;
  endfunction

  function automatic ctlT observed();
    ctlT o;
    o = '{a: ifc.ex_op_a_sel_o, b: ifc.ex_op_b_sel_o, alu: ifc.alu_op_o, req: ifc.mem_req_o,
          we: ifc.mem_we_o, size: ifc.mem_size_o, gpr: ifc.gpr_we_a_o, wb: ifc.wb_src_sel_o,
          ill: ifc.illegal_instr_o, br: ifc.branch_o, jal: ifc.jal_o, jalr: ifc.jalr_o};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] w);
    @(negedge clk);
    ifc.fetched_instr_i = w;
    @(posedge clk);
    #1;
  endtask

  task automatic chkAll(input logic [31:0] w);
    ctlT e, o;
    e = model(w); o = observed();
    chk($sformatf("%08h ctl", w), 32'(o), 32'(e));
  endtask

  initial begin
    logic [31:0] w;
    logic [4:0] opList [12] = '{LOAD_OPCODE, MISC_MEM_OPCODE, OP_IMM_OPCODE, AUIPC_OPCODE,
                                STORE_OPCODE, OP_OPCODE, LUI_OPCODE, BRANCH_OPCODE,
                                JALR_OPCODE, JAL_OPCODE, SYSTEM_OPCODE, 5'b11111};
    ifc.fetched_instr_i = 32'h0;

    // Outputs must follow the instruction even while reset is held.
    apply(32'h00500093);
    chk("rst ADDI ill", 32'(ifc.illegal_instr_o), 0);
    chk("rst ADDI gpr", 32'(ifc.gpr_we_a_o), 1);
    apply(32'h00000000);
    chk("rst zero ill", 32'(ifc.illegal_instr_o), 1);
    arstn = 1'b1;

    apply(32'h00500093); chkAll(32'h00500093);
    chk("ADDI alu", 32'(ifc.alu_op_o), 32'(ALU_ADD));
    chk("ADDI req", 32'(ifc.mem_req_o), 0);
    apply(32'h0040A103); chkAll(32'h0040A103);
    chk("LW wb", 32'(ifc.wb_src_sel_o), 32'(WB_LSU_DATA));
    chk("LW size", 32'(ifc.mem_size_o), 32'(LDST_W));
    apply(32'h0040B103); chkAll(32'h0040B103);
    chk("LD f3=3 ill", 32'(ifc.illegal_instr_o), 1);
    chk("LD f3=3 req", 32'(ifc.mem_req_o), 0);
    apply(32'h0020A223); chkAll(32'h0020A223);
    chk("SW b", 32'(ifc.ex_op_b_sel_o), 32'(OP_B_IMM_S));
    chk("SW we", 32'(ifc.mem_we_o), 1);
    apply(32'h402081B3); chkAll(32'h402081B3);
    chk("SUB alu", 32'(ifc.alu_op_o), 32'(ALU_SUB));
    apply(32'h202081B3); chkAll(32'h202081B3);
    chk("OP f7=10 ill", 32'(ifc.illegal_instr_o), 1);
    apply(32'h00208463); chkAll(32'h00208463);
    chk("BEQ alu", 32'(ifc.alu_op_o), 32'(ALU_EQ));
    chk("BEQ br", 32'(ifc.branch_o), 1);
    apply(32'h0020A463); chkAll(32'h0020A463);
    chk("BR f3=2 br", 32'(ifc.branch_o), 0);
    apply(32'h008000EF); chkAll(32'h008000EF);
    chk("JAL jal", 32'(ifc.jal_o), 1);
    chk("JAL a", 32'(ifc.ex_op_a_sel_o), 32'(OP_A_CURR_PC));
    apply(32'h00000000); chkAll(32'h00000000);
    chk("zero gpr", 32'(ifc.gpr_we_a_o), 0);
    chk("zero size", 32'(ifc.mem_size_o), 32'(LDST_W));

    // Random words biased toward real opcodes and the interesting funct7 values.
    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[1:0] = 2'b11;
      if ($urandom_range(0, 7) != 0) w[6:2] = opList[$urandom_range(0, 11)];
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
      apply(w);
      chkAll(w);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/riscv_instr_decoder.md
Name: riscv_instr_decoder

Overview:
Main decoder of the single-cycle RV32I core. It takes the 32-bit fetched instruction and produces every datapath control: ALU operand selects, ALU operation, LSU request/size/direction, register-file write enable, write-back source, and branch/jump flags. It also flags illegal instructions. All decode values use the shared `defines.v` symbols: OP_A_*, OP_B_*, ALU_*, LDST_*, WB_*, the *_OPCODE constants and ALU_OP_WIDTH.

Parameters:
None.

Ports:
clk_i  input  1  core clock; the decode path does not use it
arstn_i  input  1  asynchronous active-low reset; the decode path does not use it
fetched_instr_i  input  32  instruction word
ex_op_a_sel_o  output  2  OP_A_RS1 / OP_A_CURR_PC / OP_A_ZERO
ex_op_b_sel_o  output  3  OP_B_RS2 / OP_B_IMM_I / OP_B_IMM_U / OP_B_IMM_S / OP_B_INCR
alu_op_o  output  ALU_OP_WIDTH  ALU_* operation code
mem_req_o  output  1  LSU access request
mem_we_o  output  1  LSU write (1 = store)
mem_size_o  output  3  LDST_B/H/W/BU/HU
gpr_we_a_o  output  1  register-file write enable
wb_src_sel_o  output  1  WB_EX_RESULT / WB_LSU_DATA
illegal_instr_o  output  1  instruction not supported
branch_o  output  1  conditional branch
jal_o  output  1  JAL
jalr_o  output  1  JALR

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- The block holds no state. All outputs are a pure combinational function of fetched_instr_i, including while reset is asserted. Outputs must settle within the same cycle.
- Decode fields: opcode = instr[6:2]; instr[1:0] must be 2'b11; funct3 = [14:12]; funct7 = [31:25].
- Defaults, used for illegal instructions and as don't-care fill:
  - a = RS1, b = IMM_I, alu = ADD, size = LDST_W, wb = EX_RESULT
  - mem_req = mem_we = gpr_we = branch = jal = jalr = 0
- Outputs must always carry a legal encoding, including on illegal instructions.
- LOAD (00000): RS1, IMM_I, ADD; mem_req=1, we=0; size = funct3; gpr_we=1; wb = LSU_DATA.
  - Only funct3 0, 1, 2, 4, 5 are legal.
- MISC_MEM (00011): legal, no side effects (all enables 0).
- OP_IMM (00100): RS1, IMM_I; gpr_we=1; wb = EX. ALU op by funct3:
  - 0 ADD, 1 SLL, 2 SLTS, 3 SLTU, 4 XOR, 5 SRL/SRA, 6 OR, 7 AND.
  - SLLI requires funct7 = 0x00.
  - funct3=5 requires funct7 0x00 (SRL) or 0x20 (SRA).
  - Any other funct7 on those shifts is illegal.
- AUIPC (00101): CURR_PC, IMM_U, ADD, gpr_we=1.
- STORE (01000): RS1, IMM_S, ADD; mem_req=1, we=1; size = funct3; gpr_we=0.
  - Only funct3 0..2 are legal.
- OP (01100): RS1, RS2; gpr_we=1.
  - funct7 0x00: same funct3 mapping as OP_IMM.
  - funct7 0x20 is legal only with funct3=0 (SUB) and funct3=5 (SRA).
  - Any other funct7 is illegal.
- LUI (01101): ZERO, IMM_U, ADD, gpr_we=1.
- BRANCH (11000): RS1, RS2, branch_o=1, gpr_we=0. ALU op by funct3:
  - 0 EQ, 1 NE, 4 LTS, 5 GES, 6 LTU, 7 GEU.
  - funct3 2 and 3 are illegal.
- JALR (11001): CURR_PC, INCR, ADD, gpr_we=1, jalr_o=1. funct3 is not checked.
- JAL (11011): CURR_PC, INCR, ADD, gpr_we=1, jal_o=1.
- SYSTEM (11100): legal, no side effects (all enables 0).
- Illegal instructions:
  - Any other opcode, instr[1:0] != 11, or a disallowed funct3/funct7 combination sets illegal_instr_o=1.
  - mem_req, mem_we, gpr_we, branch, jal and jalr are all forced to 0.
- Outside loads, wb_src_sel_o = EX_RESULT.
- Outside loads and stores, mem_size_o = LDST_W and mem_we_o = 0.

Test Plan:
- 0x00500093 (ADDI) -> a=RS1, b=IMM_I, ALU_ADD, gpr_we=1, wb=EX, illegal=0, mem_req=0.
- 0x0040A103 (LW) -> mem_req=1, we=0, size=LDST_W, wb=LSU_DATA, gpr_we=1. Same word with funct3=3 -> illegal=1, mem_req=0, gpr_we=0.
- 0x0020A223 (SW) -> b=IMM_S, mem_req=1, we=1, size=LDST_W, gpr_we=0.
- 0x402081B3 (SUB) -> a=RS1, b=RS2, ALU_SUB. Same word with funct7=0x10 (0x202081B3) -> illegal=1.
- 0x00208463 (BEQ) -> branch=1, ALU_EQ, b=RS2, gpr_we=0. Same word with funct3=2 -> illegal=1, branch=0.
- 0x008000EF (JAL) -> jal=1, a=CURR_PC, b=INCR, gpr_we=1. 0x00000000 -> illegal=1, all enables 0, all selects legal.
